// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache miss-service engine.
package cache_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned BEAT_W = 16;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    EV_RD,
    EV_CAP,
    EV_CMD,
    EV_DAT,
    FL_CMD,
    FL_DAT,
    FL_WR
  } mover_state_t;

endpackage

// File: rtl/cache_line_shift_reg.sv
// One-line staging register: parallel load, or shift right by one beat with a new high beat.
module cache_line_shift_reg
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              shift,
  input  logic [BEAT_W-1:0] shift_in,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_line;
    end else if (shift) begin
      line_d = {shift_in, line_q[LINE_W-1:BEAT_W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/cache_line_mover.sv
// Miss-service engine: optional dirty-victim eviction to DRAM, 8-beat line fill,
// then a single full-line write into cache_data.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W = 16,
  parameter int unsigned SEG_W = 9,
  parameter int unsigned WAY_W = 2
) (
  input  logic                   main_clk,
  input  logic                   main_reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEG_W-1:0]       req_segment,
  input  logic [WAY_W-1:0]       req_way,
  input  logic                   req_dirty,
  input  logic [TAG_W-1:0]       req_victim_tag,
  input  logic [TAG_W-1:0]       req_fill_tag,
  output logic [SEG_W-1:0]       cache_target_segment,
  output logic [WAY_W-1:0]       cache_target_way,
  output logic                   cache_do_full_write,
  output logic [LINE_W-1:0]      cache_raw_in,
  input  logic [LINE_W-1:0]      cache_raw_out,
  output logic                   dram_cmd_valid,
  input  logic                   dram_cmd_ready,
  output logic                   dram_cmd_write,
  output logic [TAG_W+SEG_W-1:0] dram_cmd_addr,
  output logic                   dram_wdata_valid,
  input  logic                   dram_wdata_ready,
  output logic [BEAT_W-1:0]      dram_wdata,
  input  logic                   dram_rdata_valid,
  input  logic [BEAT_W-1:0]      dram_rdata,
  output logic                   done
);

  localparam int unsigned ADDR_W = TAG_W + SEG_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  mover_state_t      state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [TAG_W-1:0]  victim_q, victim_d;
  logic [TAG_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wvalid_q, wvalid_d;
  logic              full_write_q, full_write_d;
  logic              done_q, done_d;
  logic [SEG_W-1:0]  tgt_seg_q, tgt_seg_d;
  logic [WAY_W-1:0]  tgt_way_q, tgt_way_d;

  logic              line_load;
  logic              line_shift;
  logic [BEAT_W-1:0] line_shift_in;
  logic [LINE_W-1:0] line;

  cache_line_shift_reg u_line (
    .clk       (main_clk),
    .rst       (main_reset),
    .load      (line_load),
    .load_line (cache_raw_out),
    .shift     (line_shift),
    .shift_in  (line_shift_in),
    .line      (line)
  );

  // Next state, request capture and line-register control.
  always_comb begin
    state_d       = state_q;
    seg_d         = seg_q;
    way_d         = way_q;
    victim_d      = victim_q;
    fill_d        = fill_q;
    cnt_d         = cnt_q;
    line_load     = 1'b0;
    line_shift    = 1'b0;
    line_shift_in = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          seg_d    = req_segment;
          way_d    = req_way;
          victim_d = req_victim_tag;
          fill_d   = req_fill_tag;
          state_d  = req_dirty ? EV_RD : FL_CMD;
        end
      end
      EV_RD:  state_d = EV_CAP;
      EV_CAP: begin
        line_load = 1'b1;
        state_d   = EV_CMD;
      end
      EV_CMD: if (dram_cmd_ready) state_d = EV_DAT;
      EV_DAT: begin
        if (dram_wdata_ready) begin
          line_shift = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = FL_CMD;
        end
      end
      FL_CMD: if (dram_cmd_ready) state_d = FL_DAT;
      FL_DAT: begin
        if (dram_rdata_valid) begin
          line_shift    = 1'b1;
          line_shift_in = dram_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = FL_WR;
        end
      end
      FL_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with state_q.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    cmd_valid_d  = (state_d == EV_CMD) || (state_d == FL_CMD);
    cmd_write_d  = (state_d == EV_CMD);
    cmd_addr_d   = '0;
    if (state_d == EV_CMD) cmd_addr_d = {victim_d, seg_d};
    if (state_d == FL_CMD) cmd_addr_d = {fill_d, seg_d};
    wvalid_d     = (state_d == EV_DAT);
    full_write_d = (state_d == FL_WR);
    done_d       = (state_d == FL_WR);
    tgt_seg_d    = (state_d != IDLE) ? seg_d : '0;
    tgt_way_d    = (state_d != IDLE) ? way_d : '0;
  end

  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) begin
      state_q      <= IDLE;
      seg_q        <= '0;
      way_q        <= '0;
      victim_q     <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      wvalid_q     <= 1'b0;
      full_write_q <= 1'b0;
      done_q       <= 1'b0;
      tgt_seg_q    <= '0;
      tgt_way_q    <= '0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      way_q        <= way_d;
      victim_q     <= victim_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      wvalid_q     <= wvalid_d;
      full_write_q <= full_write_d;
      done_q       <= done_d;
      tgt_seg_q    <= tgt_seg_d;
      tgt_way_q    <= tgt_way_d;
    end
  end

  assign req_ready            = req_ready_q;
  assign cache_target_segment = tgt_seg_q;
  assign cache_target_way     = tgt_way_q;
  assign cache_do_full_write  = full_write_q;
  assign cache_raw_in         = line;
  assign dram_cmd_valid       = cmd_valid_q;
  assign dram_cmd_write       = cmd_write_q;
  assign dram_cmd_addr        = cmd_addr_q;
  assign dram_wdata_valid     = wvalid_q;
  assign dram_wdata           = line[BEAT_W-1:0];
  assign done                 = done_q;

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: a DRAM/cache responder, an event scoreboard
// checked every cycle, and literal expectations for the headline transactions.
module tb_cache_line_mover;

  localparam int unsigned ADDR_W = 25;

  logic          main_clk = 1'b0;
  logic          main_reset;
  logic          req_valid, req_ready, req_dirty;
  logic [8:0]    req_segment;
  logic [1:0]    req_way;
  logic [15:0]   req_victim_tag, req_fill_tag;
  logic [8:0]    cache_target_segment;
  logic [1:0]    cache_target_way;
  logic          cache_do_full_write;
  logic [127:0]  cache_raw_in, cache_raw_out;
  logic          dram_cmd_valid, dram_cmd_ready, dram_cmd_write;
  logic [24:0]   dram_cmd_addr;
  logic          dram_wdata_valid, dram_wdata_ready;
  logic [15:0]   dram_wdata;
  logic          dram_rdata_valid;
  logic [15:0]   dram_rdata;
  logic          done;

  always #5 main_clk = ~main_clk;

  cache_line_mover dut (
    .main_clk             (main_clk),
    .main_reset           (main_reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_segment          (req_segment),
    .req_way              (req_way),
    .req_dirty            (req_dirty),
    .req_victim_tag       (req_victim_tag),
    .req_fill_tag         (req_fill_tag),
    .cache_target_segment (cache_target_segment),
    .cache_target_way     (cache_target_way),
    .cache_do_full_write  (cache_do_full_write),
    .cache_raw_in         (cache_raw_in),
    .cache_raw_out        (cache_raw_out),
    .dram_cmd_valid       (dram_cmd_valid),
    .dram_cmd_ready       (dram_cmd_ready),
    .dram_cmd_write       (dram_cmd_write),
    .dram_cmd_addr        (dram_cmd_addr),
    .dram_wdata_valid     (dram_wdata_valid),
    .dram_wdata_ready     (dram_wdata_ready),
    .dram_wdata           (dram_wdata),
    .dram_rdata_valid     (dram_rdata_valid),
    .dram_rdata           (dram_rdata),
    .done                 (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Scoreboard: what the DRAM and cache_data must see, in order.
  typedef struct packed {
    logic [8:0]   seg;
    logic [1:0]   way;
    logic [127:0] line;
  } fw_t;

  logic [ADDR_W:0] exp_cmd_q[$];
  logic [15:0]     exp_w_q[$];
  fw_t             exp_fw_q[$];
  logic [ADDR_W:0] cmd_log[$];
  logic [15:0]     w_log[$];
  logic [127:0]    fw_log[$];
  int              n_acc = 0, n_dfw = 0, acc_cyc = 0, done_cyc = 0, cyc_c = 0;

  bit              exp_ready = 1'b1;
  logic [8:0]      busy_seg;
  logic [1:0]      busy_way;
  bit              prev_cmd_stall = 1'b0, prev_w_stall = 1'b0;
  logic [ADDR_W:0] prev_cmd;
  logic [15:0]     prev_wdata;

  // Compare process: sampled one time unit before each rising edge.
  always @(negedge main_clk) begin
    logic [ADDR_W:0] ec;
    logic [15:0]     ew;
    fw_t             ef;
    #4;
    cyc_c++;
    if (main_reset) begin
      chk("rst_req_ready", 128'(req_ready), 128'd1);
      chk("rst_full_write", 128'(cache_do_full_write), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_cmd_valid", 128'(dram_cmd_valid), 128'd0);
      chk("rst_wdata_valid", 128'(dram_wdata_valid), 128'd0);
      exp_ready      = 1'b1;
      prev_cmd_stall = 1'b0;
      prev_w_stall   = 1'b0;
    end else begin
      chk("req_ready", 128'(req_ready), 128'(exp_ready));
      chk("done_with_write", 128'(done), 128'(cache_do_full_write));
      if (!exp_ready) begin
        chk("target_seg", 128'(cache_target_segment), 128'(busy_seg));
        chk("target_way", 128'(cache_target_way), 128'(busy_way));
      end
      if (prev_cmd_stall) begin
        chk("cmd_held_valid", 128'(dram_cmd_valid), 128'd1);
        chk("cmd_held_fields", 128'({dram_cmd_write, dram_cmd_addr}), 128'(prev_cmd));
      end
      if (prev_w_stall) begin
        chk("wdata_held_valid", 128'(dram_wdata_valid), 128'd1);
        chk("wdata_held", 128'(dram_wdata), 128'(prev_wdata));
      end
      if (dram_cmd_valid && dram_cmd_ready) begin
        cmd_log.push_back({dram_cmd_write, dram_cmd_addr});
        if (exp_cmd_q.size() == 0) fail("unexpected_cmd", 128'({dram_cmd_write, dram_cmd_addr}));
        else begin
          ec = exp_cmd_q.pop_front();
          chk("cmd", 128'({dram_cmd_write, dram_cmd_addr}), 128'(ec));
        end
      end
      if (dram_wdata_valid && dram_wdata_ready) begin
        w_log.push_back(dram_wdata);
        if (exp_w_q.size() == 0) fail("unexpected_wbeat", 128'(dram_wdata));
        else begin
          ew = exp_w_q.pop_front();
          chk("wbeat", 128'(dram_wdata), 128'(ew));
        end
      end
      if (cache_do_full_write) begin
        n_dfw++;
        fw_log.push_back(cache_raw_in);
        if (exp_fw_q.size() == 0) fail("unexpected_full_write", cache_raw_in);
        else begin
          ef = exp_fw_q.pop_front();
          chk("fw_line", cache_raw_in, ef.line);
          chk("fw_seg", 128'(cache_target_segment), 128'(ef.seg));
          chk("fw_way", 128'(cache_target_way), 128'(ef.way));
        end
      end
      if (req_valid && req_ready) begin
        n_acc++;
        acc_cyc   = cyc_c;
        busy_seg  = req_segment;
        busy_way  = req_way;
        exp_ready = 1'b0;
      end
      if (done) begin
        done_cyc  = cyc_c;
        exp_ready = 1'b1;
      end
      prev_cmd_stall = dram_cmd_valid && !dram_cmd_ready;
      prev_cmd       = {dram_cmd_write, dram_cmd_addr};
      prev_w_stall   = dram_wdata_valid && !dram_wdata_ready;
      prev_wdata     = dram_wdata;
    end
  end

  // DRAM / cache responder state.
  logic [15:0]  fill_beat [8];
  logic [127:0] victim_line = '0;
  int  fill_left = 0, fill_idx = 0, cmd_stall_left = 0, w_stall_left = 0, w_stall_beat = -1;
  int  w_beats = 0, rst_at_beat = -1, cyc = 0;
  bit  stray_en = 0, req_pend = 0, req_hold = 0, done_seen = 0, rst_fired = 0, hold_rst = 1;
  bit  s_cmd_hs = 0, s_cmd_wr = 0, s_w_hs = 0, s_acc = 0, s_done = 0;

  // One clock: react to the last edge, drive inputs at the falling edge, sample before the rising edge.
  task automatic step();
    @(negedge main_clk);
    if (s_cmd_hs && !s_cmd_wr) begin fill_left = 8; fill_idx = 0; end
    if (s_w_hs) w_beats++;
    if (s_acc && !req_hold) req_pend = 0;
    if (s_done) begin done_seen = 1; if (req_hold) req_pend = 0; end
    main_reset = hold_rst;
    req_valid  = req_pend;
    if (dram_cmd_valid && cmd_stall_left > 0) begin dram_cmd_ready = 0; cmd_stall_left--; end
    else dram_cmd_ready = 1;
    if (dram_wdata_valid && w_beats == w_stall_beat && w_stall_left > 0) begin
      dram_wdata_ready = 0; w_stall_left--;
    end else dram_wdata_ready = 1;
    dram_rdata_valid = 0;
    dram_rdata       = '0;
    if (fill_left > 0) begin
      if (fill_idx == rst_at_beat) begin
        main_reset = 1; fill_left = 0; rst_at_beat = -1; rst_fired = 1;
        exp_cmd_q.delete(); exp_w_q.delete(); exp_fw_q.delete();
      end else begin
        dram_rdata_valid = 1; dram_rdata = fill_beat[fill_idx]; fill_idx++; fill_left--;
      end
    end else if (stray_en) begin
      dram_rdata_valid = (cyc % 2 == 0); dram_rdata = 16'hDEAD;
    end
    cache_raw_out = victim_line;
    #4;
    s_cmd_hs = dram_cmd_valid && dram_cmd_ready;
    s_cmd_wr = dram_cmd_write;
    s_w_hs   = dram_wdata_valid && dram_wdata_ready;
    s_acc    = req_valid && req_ready;
    s_done   = done;
    cyc++;
  endtask

  task automatic set_fill(input logic [15:0] base);
    for (int k = 0; k < 8; k++) fill_beat[k] = base + 16'(k);
  endtask

  task automatic issue(input logic [8:0] seg, input logic [1:0] way, input logic dirty,
                       input logic [15:0] vtag, input logic [15:0] ftag);
    fw_t f;
    req_segment = seg; req_way = way; req_dirty = dirty;
    req_victim_tag = vtag; req_fill_tag = ftag;
    if (dirty) begin
      exp_cmd_q.push_back({1'b1, vtag, seg});
      for (int k = 0; k < 8; k++) exp_w_q.push_back(victim_line[16*k +: 16]);
    end
    exp_cmd_q.push_back({1'b0, ftag, seg});
    f.seg = seg; f.way = way; f.line = '0;
    for (int k = 0; k < 8; k++) f.line[16*k +: 16] = fill_beat[k];
    exp_fw_q.push_back(f);
    w_beats = 0; done_seen = 0; req_pend = 1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_seen && n < 300) begin step(); n++; end
    if (!done_seen) fail({name, "_timeout"}, 128'(n));
    step(); step();
    chk({name, "_cmds_left"}, 128'(exp_cmd_q.size()), 128'd0);
    chk({name, "_wbeats_left"}, 128'(exp_w_q.size()), 128'd0);
    chk({name, "_writes_left"}, 128'(exp_fw_q.size()), 128'd0);
  endtask

  initial begin
    int c0, w0, d0, a0, n;
    main_reset = 1; req_valid = 0; req_segment = '0; req_way = '0; req_dirty = 0;
    req_victim_tag = '0; req_fill_tag = '0; cache_raw_out = '0;
    dram_cmd_ready = 1; dram_wdata_ready = 1; dram_rdata_valid = 0; dram_rdata = '0;
    set_fill(16'h0000);

    step(); step();
    chk("reset_raw_in", cache_raw_in, 128'd0);
    chk("reset_target_seg", 128'(cache_target_segment), 128'd0);
    chk("reset_cmd_addr", 128'(dram_cmd_addr), 128'd0);
    chk("reset_wdata", 128'(dram_wdata), 128'd0);
    hold_rst = 0;
    step(); step();
    chk("post_reset_ready", 128'(req_ready), 128'd1);

    // Clean miss, zero-wait DRAM.
    issue(9'h1A5, 2'd2, 1'b0, 16'h0000, 16'h1234);
    wait_done("clean");
    chk("clean_cmd", 128'(cmd_log[$]), 128'({1'b0, 25'h02469A5}));
    chk("clean_line", fw_log[$], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("clean_latency", 128'(done_cyc - acc_cyc), 128'd10);

    // Dirty miss: eviction of 8888..FFFF, then the same fill.
    victim_line = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    c0 = cmd_log.size(); w0 = w_log.size();
    issue(9'h1A5, 2'd2, 1'b1, 16'h00AB, 16'h1234);
    wait_done("dirty");
    chk("dirty_ev_cmd", 128'(cmd_log[c0]), 128'({1'b1, 25'h00157A5}));
    chk("dirty_wbeat_count", 128'(w_log.size() - w0), 128'd8);
    chk("dirty_first_wbeat", 128'(w_log[w0]), 128'h8888);
    chk("dirty_last_wbeat", 128'(w_log[w0+7]), 128'hFFFF);
    chk("dirty_line", fw_log[$], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("dirty_latency", 128'(done_cyc - acc_cyc), 128'd21);

    // Write backpressure: beat 4 stalled for 3 cycles.
    victim_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    set_fill(16'hA000);
    w_stall_beat = 4; w_stall_left = 3;
    w0 = w_log.size();
    issue(9'h033, 2'd1, 1'b1, 16'h5A5A, 16'h0F0F);
    wait_done("bp");
    w_stall_beat = -1;
    chk("bp_wbeat_count", 128'(w_log.size() - w0), 128'd8);
    chk("bp_wbeat4", 128'(w_log[w0+4]), 128'hCDEF);
    chk("bp_wbeat5", 128'(w_log[w0+5]), 128'h89AB);
    chk("bp_latency", 128'(done_cyc - acc_cyc), 128'd24);

    // Stray rdata_valid while idle and during eviction.
    victim_line = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    set_fill(16'h5000);
    stray_en = 1;
    for (int i = 0; i < 6; i++) step();
    issue(9'h100, 2'd3, 1'b1, 16'h0042, 16'h7777);
    wait_done("stray");
    stray_en = 0;
    chk("stray_line", fw_log[$], 128'h5007_5006_5005_5004_5003_5002_5001_5000);

    // Reset during fill beat 5, then a normal request.
    set_fill(16'h0000);
    victim_line = '0;
    d0 = n_dfw; rst_fired = 0; rst_at_beat = 5;
    issue(9'h0AA, 2'd0, 1'b0, 16'h0000, 16'hBEEF);
    n = 0;
    while (!rst_fired && n < 300) begin step(); n++; end
    if (!rst_fired) fail("rst_timeout", 128'(n));
    chk("rst_mid_ready", 128'(req_ready), 128'd1);
    chk("rst_mid_cmd_valid", 128'(dram_cmd_valid), 128'd0);
    for (int i = 0; i < 15; i++) step();
    chk("rst_no_write", 128'(n_dfw - d0), 128'd0);
    chk("rst_no_done", 128'(done_seen), 128'd0);
    set_fill(16'hC000);
    issue(9'h0AA, 2'd0, 1'b0, 16'h0000, 16'hBEEF);
    wait_done("after_rst");
    chk("after_rst_line", fw_log[$], 128'hC007_C006_C005_C004_C003_C002_C001_C000);
    chk("after_rst_latency", 128'(done_cyc - acc_cyc), 128'd10);

    // req_valid held through service, read command stalled 5 cycles.
    set_fill(16'h0000);
    req_hold = 1; cmd_stall_left = 5; a0 = n_acc;
    issue(9'h1A5, 2'd2, 1'b0, 16'h0000, 16'h1234);
    wait_done("hold");
    req_hold = 0;
    for (int i = 0; i < 3; i++) step();
    chk("hold_accepts", 128'(n_acc - a0), 128'd1);
    chk("hold_latency", 128'(done_cyc - acc_cyc), 128'd15);
    chk("hold_line", fw_log[$], 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
